chirp_capture: RTL and testbench
================================

CHIRP_CAPTURE -- requirements
Module: chirp_capture

Interface
REQ-001 Parameter FIFO_DEPTH, 4096, output byte FIFO depth in bytes (power of two).
REQ-002 Parameter MAX_SAMPLES, 2048, maximum samples accepted per chirp frame.
REQ-003 Port clk  input  1  single clock for all logic, rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port data_valid  input  1  sweep-active window from the SPI driver; a frame is its high period.
REQ-006 Port adc_data  input  12  ADC sample word.
REQ-007 Port adc_valid  input  1  one-cycle strobe, adc_data valid.
REQ-008 Port clear_ovf  input  1  clears the overflow flag.
REQ-009 Port out_ready  input  1  downstream byte sink ready.
REQ-010 Port out_data  output  8  FIFO head byte.
REQ-011 Port out_valid  output  1  out_data valid.
REQ-012 Port overflow  output  1  sticky data-loss flag.
REQ-013 Port frame_count  output  8  frames started since reset, wraps at 255->0.

Function
REQ-014 The FSM SHALL use states IDLE, HDR0, HDR1, HDR2, CAPTURE, SKIP.
REQ-015 A rising edge of data_valid (registered previous value 0, current 1) in IDLE SHALL increment frame_count and move to HDR0 if FIFO free space >= 3, else to SKIP with overflow set.
REQ-016 HDR0, HDR1, HDR2 SHALL push 0xFF, 0xFF, frame_count (post-increment value), one byte per cycle, then enter CAPTURE.
REQ-017 In CAPTURE an accepted sample SHALL push {4'h0, adc_data[11:8]} that cycle and adc_data[7:0] the next cycle; 0xFF,0xFF therefore never occurs inside sample data.
REQ-018 A sample is accepted only if: state CAPTURE, adc_valid=1, no low byte pending, free space >= 2, per-frame count < MAX_SAMPLES.
REQ-019 A strobe rejected for pending low byte or free space < 2 SHALL set overflow; a strobe rejected for MAX_SAMPLES SHALL be silently dropped.
REQ-020 Strobes during HDR0..HDR2, IDLE and SKIP SHALL be ignored without setting overflow.
REQ-021 data_valid low in CAPTURE or SKIP SHALL return to IDLE next cycle; a pending low byte SHALL still be pushed.
REQ-022 data_valid falling during HDR0..HDR2 SHALL complete the header, then go to IDLE.
REQ-023 out_valid SHALL equal FIFO not-empty; out_data SHALL be the head byte (first-word fall-through, zero latency); a byte pops when out_valid && out_ready.
REQ-024 Simultaneous push and pop SHALL both take effect; free space computed from registered occupancy before that cycle's pop.
REQ-025 overflow SHALL stay high until clear_ovf; clear_ovf coincident with a new overflow event leaves overflow=1.
REQ-026 Per-frame sample count SHALL reset to 0 on every HDR0 entry.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, FIFO empty, out_valid=0, out_data=0, overflow=0, frame_count=0, pending low byte cleared.
REQ-028 The data_valid history register SHALL reset to 1, so data_valid already high at reset release starts no frame.
REQ-029 rst asserted mid-frame SHALL discard all FIFO contents; no partial frame completes.

Structure
REQ-030 Shared package/include SHALL hold HDR_BYTE (8'hFF), HDR_LEN (3), FSM state encodings, default FIFO_DEPTH and MAX_SAMPLES.
REQ-031 One sub-module byte_fifo (8-bit, FWFT, occupancy output, async active-high reset) SHALL implement storage; chirp_capture holds FSM, packing and flags.

Verification
REQ-032 Reset, data_valid 0->1, samples 0xABC, 0x123 spaced 4 cycles, data_valid low, out_ready=1 -> bytes FF FF 01 0A BC 01 23, overflow=0.
REQ-033 adc_valid on two consecutive cycles in CAPTURE (0x456, 0x789) -> only 04 56 pushed, overflow=1; clear_ovf pulse -> overflow=0.
REQ-034 out_ready=0, frames until FIFO holds 4095 bytes, new data_valid edge -> frame_count increments, no header pushed, overflow=1, state SKIP until data_valid low.
REQ-035 MAX_SAMPLES=4, 6 samples in one frame -> exactly 3+8 bytes, overflow=0.
REQ-036 256 frames -> frame_count and header byte 3 wrap 0xFF->0x00.
REQ-037 rst pulse mid-CAPTURE with 10 bytes queued -> out_valid=0 immediately (async), frame_count=0, no frame started while data_valid stays high after release.

Source files
------------

// File: rtl/chirp_capture_pkg.sv
// Shared constants, FSM encoding and helpers for the chirp capture block.
package chirp_capture_pkg;

  localparam int unsigned FIFO_DEPTH_DEF  = 4096;
  localparam int unsigned MAX_SAMPLES_DEF = 2048;

  localparam logic [7:0]  HDR_BYTE = 8'hFF;
  localparam int unsigned HDR_LEN  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR0    = 3'd1,
    HDR1    = 3'd2,
    HDR2    = 3'd3,
    CAPTURE = 3'd4,
    SKIP    = 3'd5
  } state_e;

  // High byte of a packed sample; the zero top nibble keeps 0xFF out of sample data.
  function automatic logic [7:0] sample_hi(input logic [11:0] s);
    return {4'h0, s[11:8]};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide first-word fall-through FIFO with occupancy output.
module byte_fifo #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          not_empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign not_empty = (count_q != '0);
  assign do_push   = push && (count_q != FULL);
  assign do_pop    = pop && not_empty;
  assign count     = count_q;
  assign rdata     = not_empty ? mem[rptr_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/chirp_capture.sv
// Frames ADC samples from a chirp sweep into a byte stream: FF FF <frame> then hi/lo byte pairs.
module chirp_capture
  import chirp_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned MAX_SAMPLES = MAX_SAMPLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic        clear_ovf,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        overflow,
  output logic [7:0]  frame_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);

  state_e        state_q;
  logic          dv_q;
  logic [7:0]    fc_q;
  logic          ovf_q;
  logic          lo_pend_q;
  logic [7:0]    lo_byte_q;
  logic [CW-1:0] samp_cnt_q;

  logic [AW:0]   occ, free;
  logic          rise, hdr_room, samp_room, in_cap, accept, ovf_evt;
  logic          push, pop;
  logic [7:0]    wdata;

  assign free      = (AW + 1)'(FIFO_DEPTH) - occ;
  assign rise      = data_valid && !dv_q;
  // A low byte still draining this cycle eats one slot ahead of the header.
  assign hdr_room  = free >= ((AW + 1)'(HDR_LEN) + (AW + 1)'(lo_pend_q));
  assign samp_room = samp_cnt_q < CW'(MAX_SAMPLES);
  assign in_cap    = (state_q == CAPTURE);
  assign accept    = in_cap && adc_valid && !lo_pend_q && (free >= (AW + 1)'(2)) && samp_room;
  assign ovf_evt   = (in_cap && adc_valid && samp_room && (lo_pend_q || free < (AW + 1)'(2)))
                  || (state_q == IDLE && rise && !hdr_room);
  assign pop       = out_valid && out_ready;

  always_comb begin
    push  = 1'b0;
    wdata = 8'h00;
    if (lo_pend_q) begin
      push  = 1'b1;
      wdata = lo_byte_q;
    end else begin
      case (state_q)
        HDR0, HDR1: begin
          push  = 1'b1;
          wdata = HDR_BYTE;
        end
        HDR2: begin
          push  = 1'b1;
          wdata = fc_q;
        end
        CAPTURE: begin
          push  = accept;
          wdata = sample_hi(adc_data);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dv_q       <= 1'b1;
      fc_q       <= 8'h00;
      ovf_q      <= 1'b0;
      lo_pend_q  <= 1'b0;
      lo_byte_q  <= 8'h00;
      samp_cnt_q <= '0;
    end else begin
      dv_q <= data_valid;

      if (ovf_evt)        ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;

      if (accept) begin
        lo_pend_q  <= 1'b1;
        lo_byte_q  <= adc_data[7:0];
        samp_cnt_q <= samp_cnt_q + CW'(1);
      end else if (lo_pend_q) begin
        lo_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rise) begin
            fc_q <= fc_q + 8'd1;
            if (hdr_room) begin
              state_q    <= HDR0;
              samp_cnt_q <= '0;
            end else begin
              state_q <= SKIP;
            end
          end
        end
        HDR0:    state_q <= HDR1;
        HDR1:    state_q <= HDR2;
        HDR2:    state_q <= data_valid ? CAPTURE : IDLE;
        CAPTURE: if (!data_valid) state_q <= IDLE;
        SKIP:    if (!data_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     (wdata),
    .pop       (pop),
    .rdata     (out_data),
    .not_empty (out_valid),
    .count     (occ)
  );

  assign overflow    = ovf_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_chirp_capture.sv
// Self-checking bench for chirp_capture: scenario tasks against a byte-queue reference model.
module tb_chirp_capture;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned MAXS  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        clear_ovf;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        overflow;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] fc_model;

  chirp_capture #(
    .FIFO_DEPTH  (DEPTH),
    .MAX_SAMPLES (MAXS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_valid  (data_valid),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .clear_ovf   (clear_ovf),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // A byte seen with valid&&ready at the falling edge pops on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input logic [11:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick(1);
    adc_valid = 1'b0;
  endtask

  // One full frame of nsamp strobes; the model keeps only the first MAXS samples.
  task automatic run_frame(input int nsamp, input bit rnd);
    logic [11:0] v;
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(fc_model);
    tick(5);
    for (int i = 0; i < nsamp; i++) begin
      v = 12'($urandom);
      send_sample(v);
      if (i < int'(MAXS)) begin
        exp_q.push_back({4'h0, v[11:8]});
        exp_q.push_back(v[7:0]);
      end
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        tick(1 + int'($urandom_range(0, 2)));
      end else begin
        tick(1);
      end
    end
    tick(1);
    data_valid = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < exp_q.size() + 200 && got_q.size() < exp_q.size(); i++) tick(1);
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b1; adc_data = '0; adc_valid = 1'b0;
    clear_ovf = 1'b0; out_ready = 1'b0;
    fc_model = 8'h00;
    tick(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %02h want 00", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (frame_count !== 8'h00) begin errors++; $display("FAIL reset_frame_count got %02h want 00", frame_count); end
    rst = 1'b0;
    tick(6);
    checks++; if (frame_count !== 8'h00) begin errors++; $display("FAIL dv_high_at_release frame_count got %02h want 00", frame_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dv_high_at_release out_valid got %b want 0", out_valid); end
    data_valid = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    out_ready  = 1'b1;
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    tick(5);
    send_sample(12'hABC);
    tick(3);
    send_sample(12'h123);
    tick(2);
    data_valid = 1'b0;
    tick(2);
    exp_q = '{8'hFF, 8'hFF, fc_model, 8'h0A, 8'hBC, 8'h01, 8'h23};
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b want 0", overflow); end
    checks++; if (frame_count !== fc_model) begin errors++; $display("FAIL basic_frame_count got %02h want %02h", frame_count, fc_model); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    out_ready  = 1'b1;
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    tick(5);
    adc_data = 12'h456; adc_valid = 1'b1;
    tick(1);
    adc_data = 12'h789;
    tick(1);
    adc_valid = 1'b0;
    tick(2);
    data_valid = 1'b0;
    tick(2);
    exp_q = '{8'hFF, 8'hFF, fc_model, 8'h04, 8'h56};
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow_set got %b want 1", overflow); end
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow_clear got %b want 0", overflow); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_max_samples();
    out_ready = 1'b1;
    run_frame(6, 1'b0);
    drain();
    checks++; if (got_q.size() != 3 + 2 * MAXS) begin errors++; $display("FAIL max_len got %0d want %0d", got_q.size(), 3 + 2 * MAXS); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL max_overflow got %b want 0", overflow); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(0, 6)), 1'b1);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %b want 0", overflow); end
    checks++; if (frame_count !== fc_model) begin errors++; $display("FAIL rand_frame_count got %02h want %02h", frame_count, fc_model); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_header_abort();
    out_ready  = 1'b1;
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    exp_q = '{8'hFF, 8'hFF, fc_model};
    tick(1);
    data_valid = 1'b0;
    tick(4);
    send_sample(12'h5A5);
    tick(3);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL hdr_abort_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL hdr_abort_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hdr_abort_overflow got %b want 0", overflow); end
    exp_q.delete(); got_q.delete();
  endtask

  // Fill to DEPTH-1 bytes with full frames plus one header-only frame; frame_count wraps on the way.
  task automatic test_fill_and_wrap();
    int nfull;
    out_ready = 1'b0;
    nfull = (int'(DEPTH) - 1) / (3 + 2 * int'(MAXS));
    for (int f = 0; f < nfull; f++) run_frame(int'(MAXS), 1'b0);
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(fc_model);
    tick(1);
    data_valid = 1'b0;
    tick(5);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_before got %b want 0", overflow); end
    data_valid = 1'b1;
    fc_model   = fc_model + 8'd1;
    tick(3);
    checks++; if (frame_count !== fc_model) begin errors++; $display("FAIL skip_frame_count got %02h want %02h", frame_count, fc_model); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL skip_overflow got %b want 1", overflow); end
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    send_sample(12'h321);
    tick(3);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL skip_strobe_ignored overflow got %b want 0", overflow); end
    data_valid = 1'b0;
    tick(2);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== fc_model) begin errors++; $display("FAIL wrap_frame_count got %02h want %02h", frame_count, fc_model); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    out_ready  = 1'b0;
    data_valid = 1'b1;
    tick(5);
    for (int i = 0; i < 4; i++) begin
      send_sample(12'($urandom));
      if (i < 3) tick(1);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_queued out_valid got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_rst out_data got %02h want 00", out_data); end
    checks++; if (frame_count !== 8'h00) begin errors++; $display("FAIL mid_rst frame_count got %02h want 00", frame_count); end
    tick(2);
    rst = 1'b0;
    tick(6);
    checks++; if (frame_count !== 8'h00) begin errors++; $display("FAIL mid_release frame_count got %02h want 00", frame_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release out_valid got %b want 0", out_valid); end
    exp_q.delete(); got_q.delete();
    fc_model   = 8'h00;
    data_valid = 1'b0;
    tick(2);
    out_ready = 1'b1;
    run_frame(2, 1'b0);
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_after_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_after_byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max_samples();
    test_random_frames();
    test_header_abort();
    test_fill_and_wrap();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
